// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared PUF collector/sequencer types and helpers
package puf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_COMPARE = 2'd2,
      ST_OUTPUT  = 2'd3
   } puf_state_e;

   // Width of an index that walks the NUM_LOOPS/2 loop pairs (never below 1 bit).
   function automatic int pair_idx_width(input int num_loops);
      return (num_loops / 2 > 1) ? $clog2(num_loops / 2) : 1;
   endfunction

endpackage

// File: rtl/puf_pair_comparator.sv
// rtl/puf_pair_comparator.sv - saturating accumulate plus pairwise sum compare
module puf_pair_comparator #(
   parameter int COUNT_BITS = 16,
   parameter int SUM_BITS   = 20,
   parameter int THRESHOLD  = 4
) (
   input  logic [SUM_BITS-1:0]   sum_a_i,
   input  logic [SUM_BITS-1:0]   sum_b_i,
   input  logic [COUNT_BITS-1:0] add_i,
   output logic [SUM_BITS-1:0]   acc_sum_o,
   output logic                  a_gt_b_o,
   output logic                  reliable_o
);

   logic [SUM_BITS:0]   add_full;
   logic [SUM_BITS-1:0] abs_diff;

   // One extra carry bit detects overflow; an overflowing sum pins at all-ones.
   always_comb begin
      add_full  = {1'b0, sum_a_i} + (SUM_BITS+1)'(add_i);
      acc_sum_o = add_full[SUM_BITS] ? '1 : add_full[SUM_BITS-1:0];
   end

   // Strict greater-than so a tie reads as 0; reliability uses the magnitude of the gap.
   always_comb begin
      a_gt_b_o   = (sum_a_i > sum_b_i);
      abs_diff   = a_gt_b_o ? (sum_a_i - sum_b_i) : (sum_b_i - sum_a_i);
      reliable_o = (abs_diff >= SUM_BITS'(THRESHOLD));
   end

endmodule

// File: rtl/puf_response_collector.sv
// rtl/puf_response_collector.sv - accumulates RO counts per loop and derives masked PUF response
module puf_response_collector
   import puf_pkg::*;
#(
   parameter int NUM_LOOPS  = 4,
   parameter int COUNT_BITS = 16,
   parameter int SUM_BITS   = 20,
   parameter int THRESHOLD  = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [$clog2(NUM_LOOPS-1):0]     select_puf,
   input  logic                             store_response_puf,
   input  logic [COUNT_BITS-1:0]            count_in,
   input  logic                             done,
   output logic                             next_enable,
   output logic [NUM_LOOPS/2-1:0]           response,
   output logic [NUM_LOOPS/2-1:0]           response_mask,
   output logic                             response_valid,
   input  logic                             response_ready,
   output logic                             sel_error
);

   localparam int SEL_W     = $clog2(NUM_LOOPS-1) + 1;
   localparam int NUM_PAIRS = NUM_LOOPS / 2;
   localparam int PAIR_W    = pair_idx_width(NUM_LOOPS);

   puf_state_e                state_q, state_d;
   logic [PAIR_W-1:0]         pair_q, pair_d;
   logic [SUM_BITS-1:0]       sum_q [NUM_LOOPS];
   logic [SUM_BITS-1:0]       sum_d [NUM_LOOPS];
   logic [NUM_PAIRS-1:0]      resp_q, resp_d;
   logic [NUM_PAIRS-1:0]      mask_q, mask_d;
   logic                      sel_err_q, sel_err_d;

   logic [SEL_W-1:0]          idx_a, idx_b;
   logic [SUM_BITS-1:0]       op_a, op_b;
   logic [SUM_BITS-1:0]       acc_sum;
   logic                      a_gt_b;
   logic                      reliable;
   logic                      sel_in_range;

   assign sel_in_range = (32'(select_puf) < 32'(NUM_LOOPS));

   // The shared datapath sees the selected loop while collecting and pair 2k/2k+1 while comparing.
   always_comb begin
      if (state_q == ST_COMPARE) begin
         idx_a = SEL_W'({pair_q, 1'b0});
         idx_b = SEL_W'({pair_q, 1'b1});
      end else begin
         idx_a = select_puf;
         idx_b = '0;
      end
   end

   // Operand mux over the accumulator bank.
   always_comb begin
      op_a = '0;
      op_b = '0;
      for (int i = 0; i < NUM_LOOPS; i++) begin
         if (idx_a == SEL_W'(i)) op_a = sum_q[i];
         if (idx_b == SEL_W'(i)) op_b = sum_q[i];
      end
   end

   puf_pair_comparator #(
      .COUNT_BITS (COUNT_BITS),
      .SUM_BITS   (SUM_BITS),
      .THRESHOLD  (THRESHOLD)
   ) u_cmp (
      .sum_a_i    (op_a),
      .sum_b_i    (op_b),
      .add_i      (count_in),
      .acc_sum_o  (acc_sum),
      .a_gt_b_o   (a_gt_b),
      .reliable_o (reliable)
   );

   // Next-state logic: a start clears the bank; store is folded in before done moves on.
   always_comb begin
      state_d   = state_q;
      pair_d    = pair_q;
      sum_d     = sum_q;
      resp_d    = resp_q;
      mask_d    = mask_q;
      sel_err_d = sel_err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_COLLECT;
               sum_d     = '{default: '0};
               sel_err_d = 1'b0;
               resp_d    = '0;
               mask_d    = '0;
            end
         end
         ST_COLLECT: begin
            if (start) begin
               sum_d     = '{default: '0};
               sel_err_d = 1'b0;
               resp_d    = '0;
               mask_d    = '0;
            end else begin
               if (store_response_puf) begin
                  if (sel_in_range) begin
                     for (int i = 0; i < NUM_LOOPS; i++) begin
                        if (select_puf == SEL_W'(i)) sum_d[i] = acc_sum;
                     end
                  end else begin
                     sel_err_d = 1'b1;
                  end
               end
               if (done) begin
                  state_d = ST_COMPARE;
                  pair_d  = '0;
               end
            end
         end
         ST_COMPARE: begin
            resp_d[pair_q] = a_gt_b;
            mask_d[pair_q] = reliable;
            if (pair_q == PAIR_W'(NUM_PAIRS - 1)) begin
               state_d = ST_OUTPUT;
            end else begin
               pair_d = pair_q + 1'b1;
            end
         end
         ST_OUTPUT: begin
            if (response_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset aborts any evaluation in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         pair_q    <= '0;
         sum_q     <= '{default: '0};
         resp_q    <= '0;
         mask_q    <= '0;
         sel_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pair_q    <= pair_d;
         sum_q     <= sum_d;
         resp_q    <= resp_d;
         mask_q    <= mask_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign next_enable    = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
   assign response_valid = (state_q == ST_OUTPUT);
   assign response       = resp_q;
   assign response_mask  = mask_q;
   assign sel_error      = sel_err_q;

endmodule

// File: tb/tb_puf_response_collector.sv
// tb/tb_puf_response_collector.sv - directed self-checking bench for puf_response_collector
module tb_puf_response_collector;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  select_puf = '0;
   logic        store = 1'b0;
   logic [15:0] count_in = '0;
   logic        done = 1'b0;
   logic        response_ready = 1'b0;

   logic        ne, valid, sel_err;
   logic [1:0]  resp, mask;
   logic        ne17, valid17, sel_err17;
   logic [1:0]  resp17, mask17;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   puf_response_collector dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .select_puf         (select_puf),
      .store_response_puf (store),
      .count_in           (count_in),
      .done               (done),
      .next_enable        (ne),
      .response           (resp),
      .response_mask      (mask),
      .response_valid     (valid),
      .response_ready     (response_ready),
      .sel_error          (sel_err)
   );

   puf_response_collector #(.SUM_BITS(17)) dut17 (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .select_puf         (select_puf),
      .store_response_puf (store),
      .count_in           (count_in),
      .done               (done),
      .next_enable        (ne17),
      .response           (resp17),
      .response_mask      (mask17),
      .response_valid     (valid17),
      .response_ready     (response_ready),
      .sel_error          (sel_err17)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_store(input logic [2:0] s, input logic [15:0] c);
      select_puf = s;
      count_in   = c;
      store      = 1'b1;
      tick();
      store      = 1'b0;
   endtask

   // Done pulse plus the two compare cycles; afterwards the DUT should be in OUTPUT.
   task automatic do_done;
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      tick();
   endtask

   task automatic accept;
      response_ready = 1'b1;
      tick();
      response_ready = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      checks++; if (ne !== 1'b1) begin errors++; $display("FAIL reset_ne got=%b exp=1", ne); end
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL reset_resp got=%b exp=00", resp); end
      checks++; if (mask !== 2'b00) begin errors++; $display("FAIL reset_mask got=%b exp=00", mask); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
      checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got=%b exp=0", sel_err); end
      checks++; if (dut.sum_q[0] !== 20'd0) begin errors++; $display("FAIL reset_sum0 got=%0d exp=0", dut.sum_q[0]); end
      tick();
      reset = 1'b1;
      tick();
   endtask

   // loop sums 202/185/100/121 -> pair0 gt by 17, pair1 lt by 21
   task automatic test_basic;
      pulse_start();
      checks++; if (ne !== 1'b1) begin errors++; $display("FAIL basic_ne_collect got=%b exp=1", ne); end
      do_store(3'd0, 16'd100); do_store(3'd1, 16'd90); do_store(3'd2, 16'd50); do_store(3'd3, 16'd60);
      do_store(3'd0, 16'd102); do_store(3'd1, 16'd95); do_store(3'd2, 16'd50); do_store(3'd3, 16'd61);
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++; if (ne !== 1'b0) begin errors++; $display("FAIL basic_ne_compare got=%b exp=0", ne); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_c1 got=%b exp=0", valid); end
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_c2 got=%b exp=0", valid); end
      tick();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid_c3 got=%b exp=1", valid); end
      checks++; if (resp !== 2'b01) begin errors++; $display("FAIL basic_resp got=%b exp=01", resp); end
      checks++; if (mask !== 2'b11) begin errors++; $display("FAIL basic_mask got=%b exp=11", mask); end
      checks++; if (ne !== 1'b0) begin errors++; $display("FAIL basic_ne_output got=%b exp=0", ne); end
      accept();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_idle got=%b exp=0", valid); end
      checks++; if (ne !== 1'b1) begin errors++; $display("FAIL basic_ne_idle got=%b exp=1", ne); end
   endtask

   // pair0 200 vs 200 tie; pair1 10 vs 3
   task automatic test_tie;
      pulse_start();
      do_store(3'd0, 16'd100); do_store(3'd0, 16'd100);
      do_store(3'd1, 16'd150); do_store(3'd1, 16'd50);
      do_store(3'd2, 16'd10);  do_store(3'd3, 16'd3);
      do_done();
      checks++; if (resp !== 2'b10) begin errors++; $display("FAIL tie_resp got=%b exp=10", resp); end
      checks++; if (mask !== 2'b10) begin errors++; $display("FAIL tie_mask got=%b exp=10", mask); end
      accept();
   endtask

   // pair0 gap exactly 4 (reliable), pair1 gap 3 (unreliable)
   task automatic test_threshold;
      pulse_start();
      do_store(3'd0, 16'd54); do_store(3'd1, 16'd50);
      do_store(3'd2, 16'd7);  do_store(3'd3, 16'd10);
      do_done();
      checks++; if (resp !== 2'b01) begin errors++; $display("FAIL thr_resp got=%b exp=01", resp); end
      checks++; if (mask !== 2'b01) begin errors++; $display("FAIL thr_mask got=%b exp=01", mask); end
      accept();
   endtask

   // last store shares the done cycle and must still count (loop1 20 > loop0 10)
   task automatic test_store_with_done;
      pulse_start();
      do_store(3'd0, 16'd10);
      select_puf = 3'd1; count_in = 16'd20; store = 1'b1; done = 1'b1;
      tick();
      store = 1'b0; done = 1'b0;
      tick();
      tick();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL swd_valid got=%b exp=1", valid); end
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL swd_resp got=%b exp=00", resp); end
      checks++; if (mask !== 2'b01) begin errors++; $display("FAIL swd_mask got=%b exp=01", mask); end
      accept();
   endtask

   // start during COLLECT discards the 500 on loop0
   task automatic test_restart;
      pulse_start();
      do_store(3'd0, 16'd500);
      pulse_start();
      checks++; if (ne !== 1'b1) begin errors++; $display("FAIL restart_ne got=%b exp=1", ne); end
      do_store(3'd1, 16'd100);
      do_store(3'd2, 16'd9);
      do_done();
      checks++; if (resp !== 2'b10) begin errors++; $display("FAIL restart_resp got=%b exp=10", resp); end
      checks++; if (mask !== 2'b11) begin errors++; $display("FAIL restart_mask got=%b exp=11", mask); end
      accept();
   endtask

   // 3x0xFFFF to loop0, 2x0xFFFF to loop1
   task automatic test_saturation;
      pulse_start();
      do_store(3'd0, 16'hFFFF); do_store(3'd0, 16'hFFFF); do_store(3'd0, 16'hFFFF);
      do_store(3'd1, 16'hFFFF); do_store(3'd1, 16'hFFFF);
      checks++; if (dut17.sum_q[0] !== 17'h1FFFF) begin errors++; $display("FAIL sat_sum0_17 got=%h exp=1ffff", dut17.sum_q[0]); end
      checks++; if (dut17.sum_q[1] !== 17'h1FFFE) begin errors++; $display("FAIL sat_sum1_17 got=%h exp=1fffe", dut17.sum_q[1]); end
      checks++; if (dut.sum_q[0] !== 20'h2FFFD) begin errors++; $display("FAIL sat_sum0_20 got=%h exp=2fffd", dut.sum_q[0]); end
      do_done();
      checks++; if (resp17 !== 2'b01) begin errors++; $display("FAIL sat_resp17 got=%b exp=01", resp17); end
      checks++; if (mask17 !== 2'b00) begin errors++; $display("FAIL sat_mask17 got=%b exp=00", mask17); end
      checks++; if (resp !== 2'b01) begin errors++; $display("FAIL sat_resp20 got=%b exp=01", resp); end
      checks++; if (mask !== 2'b01) begin errors++; $display("FAIL sat_mask20 got=%b exp=01", mask); end
      accept();
   endtask

   task automatic test_sel_error;
      pulse_start();
      do_store(3'd0, 16'd7);
      checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL selerr_pre got=%b exp=0", sel_err); end
      do_store(3'd5, 16'd99);
      checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL selerr_set got=%b exp=1", sel_err); end
      checks++; if (dut.sum_q[0] !== 20'd7) begin errors++; $display("FAIL selerr_sum0 got=%0d exp=7", dut.sum_q[0]); end
      checks++; if (dut.sum_q[1] !== 20'd0) begin errors++; $display("FAIL selerr_sum1 got=%0d exp=0", dut.sum_q[1]); end
      do_store(3'd4, 16'd1);
      checks++; if (dut.sum_q[0] !== 20'd7) begin errors++; $display("FAIL selerr4_sum0 got=%0d exp=7", dut.sum_q[0]); end
      checks++; if (dut.sum_q[3] !== 20'd0) begin errors++; $display("FAIL selerr4_sum3 got=%0d exp=0", dut.sum_q[3]); end
      do_store(3'd3, 16'd2);
      checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL selerr_sticky got=%b exp=1", sel_err); end
      do_done();
      accept();
      pulse_start();
      checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL selerr_clear got=%b exp=0", sel_err); end
      do_done();
      accept();
   endtask

   // consumer stalls 10 cycles while start/store/done are poked
   task automatic test_ready_hold;
      pulse_start();
      do_store(3'd0, 16'd100); do_store(3'd1, 16'd90); do_store(3'd2, 16'd50); do_store(3'd3, 16'd60);
      do_store(3'd0, 16'd102); do_store(3'd1, 16'd95); do_store(3'd2, 16'd50); do_store(3'd3, 16'd61);
      do_done();
      for (int i = 0; i < 10; i++) begin
         start = (i == 3);
         store = (i == 5);
         select_puf = 3'd0;
         count_in = 16'd1000;
         done = (i == 7);
         checks++; if (valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, valid); end
         checks++; if (resp !== 2'b01) begin errors++; $display("FAIL hold_resp[%0d] got=%b exp=01", i, resp); end
         checks++; if (mask !== 2'b11) begin errors++; $display("FAIL hold_mask[%0d] got=%b exp=11", i, mask); end
         tick();
      end
      start = 1'b0; store = 1'b0; done = 1'b0;
      checks++; if (dut.sum_q[0] !== 20'd202) begin errors++; $display("FAIL hold_sum0 got=%0d exp=202", dut.sum_q[0]); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL hold_valid_end got=%b exp=1", valid); end
      accept();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL hold_idle_valid got=%b exp=0", valid); end
      checks++; if (ne !== 1'b1) begin errors++; $display("FAIL hold_idle_ne got=%b exp=1", ne); end
   endtask

   task automatic test_reset_mid;
      pulse_start();
      do_store(3'd0, 16'd300);
      do_store(3'd5, 16'd1);
      checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL rmid_pre_selerr got=%b exp=1", sel_err); end
      reset = 1'b0;
      #2;
      checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rmid_selerr got=%b exp=0", sel_err); end
      checks++; if (dut.sum_q[0] !== 20'd0) begin errors++; $display("FAIL rmid_sum0 got=%0d exp=0", dut.sum_q[0]); end
      checks++; if (ne !== 1'b1) begin errors++; $display("FAIL rmid_ne got=%b exp=1", ne); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", valid); end
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL rmid_resp got=%b exp=00", resp); end
      tick();
      reset = 1'b1;
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_no_valid got=%b exp=0", valid); end
      pulse_start();
      do_store(3'd1, 16'd40);
      do_store(3'd2, 16'd10);
      do_done();
      checks++; if (resp !== 2'b10) begin errors++; $display("FAIL rmid_resp_new got=%b exp=10", resp); end
      checks++; if (mask !== 2'b11) begin errors++; $display("FAIL rmid_mask_new got=%b exp=11", mask); end
      accept();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_threshold();
      test_store_with_done();
      test_restart();
      test_saturation();
      test_sel_error();
      test_ready_hold();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/puf_response_collector.md
PUF_RESPONSE_COLLECTOR -- requirements
Module: puf_response_collector

Interface
REQ-001 The module SHALL have parameter NUM_LOOPS, default 4, meaning ring-oscillator loop count (even, at least 2).
REQ-002 The module SHALL have parameter COUNT_BITS, default 16, meaning the width of one oscillation count sample.
REQ-003 The module SHALL have parameter SUM_BITS, default 20, meaning the width of each per-loop accumulator.
REQ-004 The module SHALL have parameter THRESHOLD, default 4, meaning the minimum absolute sum difference for a bit to be marked reliable.
REQ-005 The module SHALL have port clk, input, 1 bit: single clock; all logic SHALL be rising-edge.
REQ-006 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port start, input, 1 bit: a one-cycle pulse that opens a new evaluation.
REQ-008 The module SHALL have port select_puf, input, $clog2(NUM_LOOPS-1)+1 bits: index of the loop that was evaluated.
REQ-009 The module SHALL have port store_response_puf, input, 1 bit: a one-cycle pulse meaning count_in is valid for select_puf.
REQ-010 The module SHALL have port count_in, input, COUNT_BITS: oscillation count of the selected loop.
REQ-011 The module SHALL have port done, input, 1 bit: the sequencer has finished all loops and repetitions.
REQ-012 The module SHALL have port next_enable, output, 1 bit: high when the collector accepts samples.
REQ-013 The module SHALL have port response, output, NUM_LOOPS/2 bits: bit k = comparison of loop 2k vs loop 2k+1.
REQ-014 The module SHALL have port response_mask, output, NUM_LOOPS/2 bits: bit k set means pair k is reliable.
REQ-015 The module SHALL have port response_valid, output, 1 bit: response and mask are held stable while this is high.
REQ-016 The module SHALL have port response_ready, input, 1 bit: consumer acceptance.
REQ-017 The module SHALL have port sel_error, output, 1 bit: sticky flag, set by a store with select_puf >= NUM_LOOPS.

Function
REQ-018 The FSM SHALL have states IDLE, COLLECT, COMPARE and OUTPUT.
REQ-019 IDLE->COLLECT SHALL occur on start; on entry, all accumulators and sel_error SHALL be cleared.
REQ-020 In COLLECT, each store_response_puf SHALL add count_in to the accumulator sum[select_puf] in that cycle, saturating at 2^SUM_BITS-1.
REQ-021 A store with an out-of-range select_puf SHALL be ignored and SHALL set sel_error.
REQ-022 COLLECT->COMPARE SHALL occur on done; if store and done occur in the same cycle, the sample SHALL be accumulated first.
REQ-023 A start received in COLLECT SHALL restart the evaluation (accumulators cleared; state stays COLLECT).
REQ-024 COMPARE SHALL evaluate one pair per cycle, k = 0 .. NUM_LOOPS/2-1, taking exactly NUM_LOOPS/2 cycles.
REQ-025 In COMPARE, response[k] SHALL be 1 if sum[2k] > sum[2k+1], else 0 (a tie gives 0).
REQ-026 In COMPARE, response_mask[k] SHALL be 1 if |sum[2k]-sum[2k+1]| >= THRESHOLD.
REQ-027 response_valid SHALL rise in the cycle after the last compare, and the state SHALL be OUTPUT.
REQ-028 In OUTPUT, response_valid SHALL stay high until response_valid && response_ready is sampled, then the state SHALL return to IDLE.
REQ-029 start, store and done SHALL be ignored in COMPARE and OUTPUT.
REQ-030 next_enable SHALL be 1 in IDLE and COLLECT only.

Reset
REQ-031 While reset=0, the state SHALL be IDLE, all accumulators 0, response 0, response_mask 0, response_valid 0, sel_error 0, and next_enable 1.
REQ-032 Reset asserted mid-operation SHALL abort immediately; no response_valid SHALL be emitted for the aborted evaluation.

Structure
REQ-033 The FSM state enum and the pair-index width function SHALL reside in the shared package puf_pkg, reused with the sequencer.
REQ-034 The saturating accumulate-and-compare datapath SHALL be a single sub-module puf_pair_comparator, instantiated once and muxed by pair index.

Verification
REQ-035 Scenario (defaults, 2 repetitions): counts loop0 100,102; loop1 90,95; loop2 50,50; loop3 60,61 -> response=2'b01, mask=2'b11, valid 3 cycles after done.
REQ-036 Scenario, tie: loop0 and loop1 both sum to 200 -> response[0]=0 and mask[0]=0.
REQ-037 Scenario (SUM_BITS=17): three stores of 0xFFFF to loop0 -> sum[0]=0x1FFFF (saturated), no wrap.
REQ-038 Scenario, select_puf=5 with a store pulse -> sel_error=1 and accumulators unchanged.
REQ-039 Scenario: response_ready held low for 10 cycles -> response_valid and data stable for the whole period, and IDLE entered the cycle after ready.
REQ-040 Scenario: reset pulsed low during COLLECT -> all outputs at reset values; a new start then collects from zero.
